// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared widths and the write-back entry type
//   XLEN       : register data width
//   REG_AW     : register address width
//   wb_entry_t : {rd, data} pair carried through the arbiter and load FIFO
package wb_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - load-result FIFO with per-entry rd/valid export
//   clk, rst        : clock, synchronous active-high reset
//   push, push_data : write one entry at the tail
//   pop, head       : remove the entry at the head / current head entry
//   count           : occupancy (0..DEPTH)
//   full, empty     : occupancy flags
//   entry_rd        : rd field of every storage slot
//   entry_valid     : slot currently holds a buffered entry
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               push,
    input  wb_entry_t                          push_data,
    input  logic                               pop,
    output wb_entry_t                          head,
    output logic [$clog2(DEPTH):0]             count,
    output logic                               full,
    output logic                               empty,
    output logic [DEPTH-1:0][REG_AW-1:0]       entry_rd,
    output logic [DEPTH-1:0]                   entry_valid
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t              mem [DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // Pointers are log2(DEPTH) wide, so plain increment wraps modulo DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Storage needs no reset: validity is derived from rd_ptr/count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // A slot is live when its distance from the head is below the occupancy.
    always_comb begin
        logic [PTR_W-1:0] offset;
        entry_rd    = '0;
        entry_valid = '0;
        offset      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset         = PTR_W'(i) - rd_ptr;
            entry_rd[i]    = mem[i].rd;
            entry_valid[i] = ({1'b0, offset} < count);
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - register-file write-back arbiter (execute vs. load)
//   clk, rst                          : clock, synchronous active-high reset
//   ex_valid/ex_rd/ex_data/ex_ready   : execute result handshake
//   ld_valid/ld_rd/ld_data/ld_ready   : load result handshake
//   w_en/waddr/wdata                  : registered register-file write port
//   q_addr1/q_addr2 -> q_hit1/q_hit2  : pending-write hazard query
//   Optional macro WB_HAZARD_EN enables the hazard comparators; otherwise
//   q_hit1/q_hit2 are tied low.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic [XLEN-1:0]   ex_data,
    output logic              ex_ready,
    input  logic              ld_valid,
    input  logic [REG_AW-1:0] ld_rd,
    input  logic [XLEN-1:0]   ld_data,
    output logic              ld_ready,
    output logic              w_en,
    output logic [REG_AW-1:0] waddr,
    output logic [XLEN-1:0]   wdata,
    input  logic [REG_AW-1:0] q_addr1,
    input  logic [REG_AW-1:0] q_addr2,
    output logic              q_hit1,
    output logic              q_hit2
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    wb_entry_t                   fifo_head;
    wb_entry_t                   ld_entry;
    wb_entry_t                   issue_entry;
    logic [CNT_W-1:0]            fifo_count;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic [DEPTH-1:0][REG_AW-1:0] fifo_rd;
    logic [DEPTH-1:0]            fifo_vld;
    logic                        sel_fifo;
    logic                        sel_ex;
    logic                        sel_ld;
    logic                        issue_valid;
    logic                        push;
    logic                        pop;

    assign ld_entry = '{rd: ld_rd, data: ld_data};

    // Neither source is accepted while the FIFO is full: a load could not be
    // buffered, and the FIFO head owns the write port that cycle.
    assign ex_ready = ~fifo_full;
    assign ld_ready = ~fifo_full;

    always_comb begin
        sel_fifo = 1'b0;
        sel_ex   = 1'b0;
        sel_ld   = 1'b0;
        if (fifo_full) begin
            sel_fifo = 1'b1;
        end else if (ex_valid) begin
            sel_ex = 1'b1;
        end else if (!fifo_empty) begin
            sel_fifo = 1'b1;
        end else if (ld_valid) begin
            sel_ld = 1'b1;
        end
    end

    always_comb begin
        issue_entry = '0;
        if (sel_fifo) begin
            issue_entry = fifo_head;
        end else if (sel_ex) begin
            issue_entry = '{rd: ex_rd, data: ex_data};
        end else if (sel_ld) begin
            issue_entry = ld_entry;
        end
    end

    assign issue_valid = sel_fifo | sel_ex | sel_ld;
    assign pop         = sel_fifo;
    // Any accepted load that did not take the direct path goes to the tail.
    assign push        = ld_valid & ~fifo_full & ~sel_ld;

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (push),
        .push_data   (ld_entry),
        .pop         (pop),
        .head        (fifo_head),
        .count       (fifo_count),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .entry_rd    (fifo_rd),
        .entry_valid (fifo_vld)
    );

    // Writes to x0 complete their handshake but never reach the register
    // file; address/data hold their last real write in that case.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_en  <= 1'b0;
            waddr <= '0;
            wdata <= '0;
        end else begin
            w_en <= issue_valid && (issue_entry.rd != '0);
            if (issue_valid && (issue_entry.rd != '0)) begin
                waddr <= issue_entry.rd;
                wdata <= issue_entry.data;
            end
        end
    end

`ifdef WB_HAZARD_EN
    always_comb begin
        logic m1;
        logic m2;
        m1 = w_en && (waddr == q_addr1);
        m2 = w_en && (waddr == q_addr2);
        for (int i = 0; i < DEPTH; i++) begin
            if (fifo_vld[i] && (fifo_rd[i] == q_addr1)) begin
                m1 = 1'b1;
            end
            if (fifo_vld[i] && (fifo_rd[i] == q_addr2)) begin
                m2 = 1'b1;
            end
        end
        q_hit1 = m1 && (q_addr1 != '0);
        q_hit2 = m2 && (q_addr2 != '0);
    end
`else
    logic unused_hazard;
    assign unused_hazard = ^{q_addr1, q_addr2, fifo_rd, fifo_vld};
    assign q_hit1 = 1'b0;
    assign q_hit2 = 1'b0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - directed self-checking bench for wb_arbiter
module tb_wb_arbiter;

`ifdef WB_HAZARD_EN
    localparam logic HZ = 1'b1;
`else
    localparam logic HZ = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [4:0]  ex_rd;
    logic [31:0] ex_data;
    logic        ex_ready;
    logic        ld_valid;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        ld_ready;
    logic        w_en;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  q_addr1;
    logic [4:0]  q_addr2;
    logic        q_hit1;
    logic        q_hit2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wb_arbiter #(.DEPTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .ex_valid (ex_valid),
        .ex_rd    (ex_rd),
        .ex_data  (ex_data),
        .ex_ready (ex_ready),
        .ld_valid (ld_valid),
        .ld_rd    (ld_rd),
        .ld_data  (ld_data),
        .ld_ready (ld_ready),
        .w_en     (w_en),
        .waddr    (waddr),
        .wdata    (wdata),
        .q_addr1  (q_addr1),
        .q_addr2  (q_addr2),
        .q_hit1   (q_hit1),
        .q_hit2   (q_hit2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_wr(input string tag, input logic [4:0] a, input logic [31:0] d);
        chk({tag, ".w_en"},  32'(w_en),  32'd1);
        chk({tag, ".waddr"}, 32'(waddr), 32'(a));
        chk({tag, ".wdata"}, wdata,      d);
    endtask

    initial begin
        rst = 1'b1; ex_valid = 0; ex_rd = 0; ex_data = 0;
        ld_valid = 0; ld_rd = 0; ld_data = 0; q_addr1 = 0; q_addr2 = 0;
        tick();
        tick();
        chk("rst.w_en",     32'(w_en),     32'd0);
        chk("rst.waddr",    32'(waddr),    32'd0);
        chk("rst.wdata",    wdata,         32'd0);
        chk("rst.ex_ready", 32'(ex_ready), 32'd1);
        chk("rst.ld_ready", 32'(ld_ready), 32'd1);
        chk("rst.q_hit1",   32'(q_hit1),   32'd0);
        chk("rst.q_hit2",   32'(q_hit2),   32'd0);
        rst = 1'b0;

        // Single execute write.
        ex_valid = 1; ex_rd = 5; ex_data = 32'hDEADBEEF;
        tick();
        ex_valid = 0;
        chk_wr("ex5", 5'd5, 32'hDEADBEEF);

        // Write to x0 is swallowed.
        ex_valid = 1; ex_rd = 0; ex_data = 32'h1234;
        chk("x0.ex_ready_pre", 32'(ex_ready), 32'd1);
        tick();
        ex_valid = 0;
        chk("x0.w_en",     32'(w_en),     32'd0);
        chk("x0.ex_ready", 32'(ex_ready), 32'd1);

        // Simultaneous execute and load: execute first, load buffered.
        ex_valid = 1; ex_rd = 1; ex_data = 32'h11;
        ld_valid = 1; ld_rd = 2; ld_data = 32'h22;
        tick();
        ex_valid = 0; ld_valid = 0; q_addr1 = 2;
        chk_wr("both.x1", 5'd1, 32'h11);
        chk("both.q_hit1", 32'(q_hit1), 32'(HZ));
        tick();
        q_addr1 = 0;
        chk_wr("both.x2", 5'd2, 32'h22);
        tick();
        chk("both.idle", 32'(w_en), 32'd0);

        // Direct load with nothing else pending.
        ld_valid = 1; ld_rd = 13; ld_data = 32'hB13;
        tick();
        ld_valid = 0;
        chk_wr("ld13", 5'd13, 32'hB13);

        // Fill the FIFO with x3..x6 while execute keeps the port busy.
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("fill%0d.ld_ready", i), 32'(ld_ready), 32'd1);
            ex_valid = 1; ex_rd = 5'(8 + i); ex_data = 32'hE8 + 32'(i);
            ld_valid = 1; ld_rd = 5'(3 + i); ld_data = 32'hA3 + 32'(i);
            tick();
            chk_wr($sformatf("fill%0d", i), 5'(8 + i), 32'hE8 + 32'(i));
        end
        ld_valid = 0;
        chk("full.ld_ready", 32'(ld_ready), 32'd0);
        chk("full.ex_ready", 32'(ex_ready), 32'd0);
        tick();
        ex_valid = 0;
        chk_wr("drain.x3", 5'd3, 32'hA3);
        chk("drain.ex_ready", 32'(ex_ready), 32'd1);
        for (int i = 1; i < 4; i++) begin
            tick();
            chk_wr($sformatf("drain.x%0d", 3 + i), 5'(3 + i), 32'hA3 + 32'(i));
        end
        tick();
        chk("drain.idle", 32'(w_en), 32'd0);

        // Hazard query on a buffered load to x7.
        ex_valid = 1; ex_rd = 1; ex_data = 32'h1;
        ld_valid = 1; ld_rd = 7; ld_data = 32'hA7;
        q_addr1 = 7; q_addr2 = 0;
        tick();
        ex_valid = 0; ld_valid = 0;
        chk("hz.buf.q_hit1", 32'(q_hit1), 32'(HZ));
        chk("hz.buf.q_hit2", 32'(q_hit2), 32'd0);
        tick();
        chk_wr("hz.x7", 5'd7, 32'hA7);
        chk("hz.out.q_hit1", 32'(q_hit1), 32'(HZ));
        tick();
        chk("hz.done.q_hit1", 32'(q_hit1), 32'd0);
        chk("hz.done.w_en",   32'(w_en),   32'd0);

        // Reset mid-operation drops buffered loads and the pending write.
        ex_valid = 1; ex_rd = 20; ex_data = 32'h20;
        ld_valid = 1; ld_rd = 21; ld_data = 32'h21;
        tick();
        ex_rd = 22; ex_data = 32'h22; ld_rd = 23; ld_data = 32'h23;
        rst = 1'b1;
        tick();
        rst = 1'b0; ex_valid = 0; ld_valid = 0; q_addr1 = 21;
        chk("mrst.w_en",     32'(w_en),     32'd0);
        chk("mrst.ex_ready", 32'(ex_ready), 32'd1);
        chk("mrst.q_hit1",   32'(q_hit1),   32'd0);
        tick();
        chk("mrst.drained",  32'(w_en),     32'd0);
        tick();
        chk("mrst.drained2", 32'(w_en),     32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
